updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
- Parametrised synchronous up/down counter. Generalises the fixed 4-bit free-running down counter.
- Adds:
  - configurable width
  - programmable terminal limit
  - parallel load and count enable
  - direction control
  - three end-of-range modes: wrap, saturate, one-shot
- Used as the general timer/divider primitive across the design, wherever a fixed-width counter was previously instantiated.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- RESET_VAL, {WIDTH{1'b1}} (15 at WIDTH=4), count value forced by reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; count steps only when high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value captured on load.
- limit  input  WIDTH  upper bound of count range; range is 0..limit.
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
- count_out  output  WIDTH  current count (registered).
- tc  output  1  terminal-count flag (combinational from count_out, up, limit).
- wrap_pulse  output  1  registered; high one cycle after a wrap event.
- done  output  1  registered; high while the one-shot has expired.

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset is asynchronous and active-high; port named reset.
  - While reset is high: count_out=RESET_VAL, wrap_pulse=0, done=0, FSM=RUN. Reset is not masked by any input.
  - Reset asserted mid-count aborts immediately. Counting resumes on the first rising edge after reset deasserts, if en=1.
- Priority per rising edge: reset > load > en. When en=0 and load=0, count_out holds.
- Load:
  - count_out<=load_val, FSM<=RUN, done<=0, wrap_pulse<=0.
  - load_val > limit is loaded unmodified.
  - Load takes priority over a simultaneous en; no count step occurs that cycle.
- Terminal condition: T = up ? (count_out >= limit) : (count_out == 0). tc = T, level, not gated by en.
- Count step when en=1, load=0, FSM=RUN:
  - Not T: count_out <= count_out +1 (up) or -1 (down). Arithmetic is WIDTH bits; limit is never exceeded by stepping, except from an out-of-range load.
  - Down from count_out > limit: decrements normally.
  - T, mode wrap/11: up -> 0, down -> limit; wrap_pulse<=1 next cycle.
  - T, mode saturate: count_out holds; no wrap_pulse.
  - T, mode one-shot: count_out holds; FSM->DONE; done<=1.
- wrap_pulse is 0 in every cycle not immediately following a wrap step.
- FSM states:
  - RUN: normal counting.
  - DONE: count_out frozen; en, up and mode are ignored; done=1.
  - DONE -> RUN only via load or reset.
- limit=0: up direction is always terminal; in wrap mode up stays at 0 and pulses wrap_pulse every enabled cycle. Down: 0 wraps to 0 with wrap_pulse.
- Changes to mode/up/limit take effect at the next edge. No internal registering of them.
- Single-cycle latency: inputs sampled at edge N are reflected on count_out after edge N.

Test Plan:
- Default legacy: WIDTH=4, mode=00, up=0, limit=15, en=1, reset pulse -> count_out 15,14,...,0,15. wrap_pulse high the cycle count shows 15 after 0.
- Up wrap with limit=9: load 7, up=1 -> 7,8,9,0,1. tc high only at 9. wrap_pulse once, coincident with 0.
- Saturate down: load 2, mode=01, up=0 -> 2,1,0,0,0. tc stays 1 at 0. wrap_pulse never asserts.
- One-shot: load 3, mode=10, down -> 3,2,1,0, done=1. Toggling en/up/mode has no effect. Load 5 -> done=0, counts 5,4...
- Priority and edges: load=1 with en=1 -> load_val captured, no step. Load 12 with limit=9, down -> 12,11,10,9. Same load counting up -> wraps to 0 on the next step.
- Async reset mid-count (between edges, count=6) -> count_out=15 immediately, done=0, wrap_pulse=0. Counting resumes on the first edge after release.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter with programmable limit, parallel load,
// count enable and three end-of-range modes (wrap, saturate, one-shot).
// Serves as the general timer/divider primitive.
module updown_mod_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             done
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             done_nxt;

    // Terminal flag is a level derived from the live count, direction and limit;
    // it is deliberately not gated by en so callers can see it while paused.
    always_comb begin
        if (up) begin
            tc = (count_out >= limit);
        end else begin
            tc = (count_out == '0);
        end
    end

    // Next-state logic: load beats counting; a frozen one-shot ignores en/up/mode.
    always_comb begin
        state_nxt = state;
        count_nxt = count_out;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = load_val;
            state_nxt = RUN;
        end else if (en && (state == RUN)) begin
            if (!tc) begin
                // A value loaded above limit still decrements normally here.
                count_nxt = up ? (count_out + ONE) : (count_out - ONE);
            end else begin
                case (mode)
                    2'b01: count_nxt = count_out;
                    2'b10: state_nxt = DONE;
                    default: begin
                        // Wrap and the reserved encoding both wrap around the range.
                        count_nxt = up ? '0 : limit;
                        wrap_nxt  = 1'b1;
                    end
                endcase
            end
        end
        done_nxt = (state_nxt == DONE);
    end

    // State and output registers, cleared immediately by asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            count_out  <= RESET_VAL;
            wrap_pulse <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count_out  <= count_nxt;
            wrap_pulse <= wrap_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: an arithmetic reference model
// checked every cycle, plus directed sequences with literal expectations.
module tb_updown_mod_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b1;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] limit = 4'd15;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] count_out;
    logic         tc;
    logic         wrap_pulse;
    logic         done;

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers.
    int m_count = MOD - 1;
    int m_wrap  = 0;
    int m_done  = 0;

    updown_mod_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_val   (load_val),
        .limit      (limit),
        .mode       (mode),
        .count_out  (count_out),
        .tc         (tc),
        .wrap_pulse (wrap_pulse),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the counter must hold after each edge.
    always @(posedge clk or posedge reset) begin
        int lim;
        int term;
        lim = int'(limit);
        if (reset) begin
            m_count = MOD - 1;
            m_wrap  = 0;
            m_done  = 0;
        end else begin
            m_wrap = 0;
            if (load) begin
                m_count = int'(load_val);
                m_done  = 0;
            end else if (en && m_done == 0) begin
                term = up ? int'(m_count >= lim) : int'(m_count == 0);
                if (term == 0) begin
                    m_count = (m_count + (up ? 1 : MOD - 1)) % MOD;
                end else if (mode == 2'b01) begin
                    m_count = m_count;
                end else if (mode == 2'b10) begin
                    m_done = 1;
                end else begin
                    m_count = up ? 0 : lim;
                    m_wrap  = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int m_tc;
        m_tc = up ? int'(m_count >= int'(limit)) : int'(m_count == 0);
        chk("model_count", int'(count_out), m_count);
        chk("model_tc", int'(tc), m_tc);
        chk("model_wrap", int'(wrap_pulse), m_wrap);
        chk("model_done", int'(done), m_done);
    end

    // Advance one edge and compare with hand-computed values.
    task automatic step(input string name, input int c, input int t, input int w, input int d);
        @(posedge clk);
        #1;
        chk({name, "_count"}, int'(count_out), c);
        chk({name, "_tc"}, int'(tc), t);
        chk({name, "_wrap"}, int'(wrap_pulse), w);
        chk({name, "_done"}, int'(done), d);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk("rst_count", int'(count_out), 15);
        chk("rst_wrap", int'(wrap_pulse), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;

        // Legacy free-running down count, wrap 0 -> 15
        for (int i = 14; i >= 0; i--) step("legacy", i, (i == 0) ? 1 : 0, 0, 0);
        step("legacy_wrap", 15, 0, 1, 0);
        step("legacy_after", 14, 0, 0, 0);

        // Up wrap with limit 9, load priority over en
        limit = 4'd9; up = 1'b1; load = 1'b1; load_val = 4'd7;
        step("upw_load", 7, 0, 0, 0);
        load = 1'b0;
        step("upw8", 8, 0, 0, 0);
        step("upw9", 9, 1, 0, 0);
        step("upw0", 0, 0, 1, 0);
        step("upw1", 1, 0, 0, 0);

        // Saturate down
        mode = 2'b01; up = 1'b0; load = 1'b1; load_val = 4'd2;
        step("sat_load", 2, 0, 0, 0);
        load = 1'b0;
        step("sat1", 1, 0, 0, 0);
        step("sat0", 0, 1, 0, 0);
        step("sat0b", 0, 1, 0, 0);
        step("sat0c", 0, 1, 0, 0);

        // One-shot down, then frozen
        mode = 2'b10; load = 1'b1; load_val = 4'd3;
        step("os_load", 3, 0, 0, 0);
        load = 1'b0;
        step("os2", 2, 0, 0, 0);
        step("os1", 1, 0, 0, 0);
        step("os0", 0, 1, 0, 0);
        step("os_done", 0, 1, 0, 1);
        en = 1'b0; up = 1'b1; mode = 2'b00;
        step("os_frz1", 0, 0, 0, 1);
        en = 1'b1;
        step("os_frz2", 0, 0, 0, 1);
        up = 1'b0; mode = 2'b10; load = 1'b1; load_val = 4'd5;
        step("os_reload", 5, 0, 0, 0);
        load = 1'b0;
        step("os4", 4, 0, 0, 0);

        // Out-of-range load above limit
        mode = 2'b00; load = 1'b1; load_val = 4'd12;
        step("oor_load", 12, 0, 0, 0);
        load = 1'b0;
        step("oor11", 11, 0, 0, 0);
        step("oor10", 10, 0, 0, 0);
        step("oor9", 9, 0, 0, 0);
        step("oor8", 8, 0, 0, 0);
        up = 1'b1; load = 1'b1;
        step("oor_up_load", 12, 1, 0, 0);
        load = 1'b0;
        step("oor_up_wrap", 0, 0, 1, 0);

        // Asynchronous reset between edges
        load = 1'b1; load_val = 4'd4;
        step("ar_load", 4, 0, 0, 0);
        load = 1'b0;
        step("ar5", 5, 0, 0, 0);
        step("ar6", 6, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("ar_imm_count", int'(count_out), 15);
        chk("ar_imm_wrap", int'(wrap_pulse), 0);
        chk("ar_imm_done", int'(done), 0);
        @(posedge clk);
        #1;
        chk("ar_hold_count", int'(count_out), 15);
        reset = 1'b0; up = 1'b0; limit = 4'd15;
        step("ar_resume", 14, 0, 0, 0);

        // limit 0: always terminal, wraps to 0 with pulse each cycle
        limit = 4'd0; up = 1'b1;
        step("lz_up1", 0, 1, 1, 0);
        step("lz_up2", 0, 1, 1, 0);
        up = 1'b0;
        step("lz_dn", 0, 1, 1, 0);
        en = 1'b0;
        step("lz_hold", 0, 1, 0, 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Run-time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
